// File: rtl/lane_judge_pkg.sv
// Shared types and constants for the multi-lane note tracker / hit judge.
package lane_judge_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    MOVE = 1'b1
  } lane_state_e;

  localparam int INC_NORMAL  = 1;
  localparam int INC_PERFECT = 2;
  localparam int COMBO_W     = 8;

endpackage

// File: rtl/lane_judge_fsm.sv
// One lane: note state, position and grading of spawn/tick/key.
// LANE_JUDGE_EARLY_MISS_EN turns a key pressed before the hit window into a miss.
module lane_fsm
  import lane_judge_pkg::*;
#(
  parameter int POS_W   = 4,
  parameter int POS_MAX = 10,
  parameter int HIT_LO  = 8,
  parameter int PERFECT = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             spawn,
  input  logic             key,
  output logic [POS_W-1:0] pos,
  output logic             active,
  output logic             hit,
  output logic             miss,
  output logic             perfect
);

  localparam logic [POS_W-1:0] POS_MAX_V = POS_W'(POS_MAX);
  localparam logic [POS_W-1:0] HIT_LO_V  = POS_W'(HIT_LO);
  localparam logic [POS_W-1:0] PERFECT_V = POS_W'(PERFECT);

  lane_state_e      state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             hit_q, hit_d;
  logic             miss_q, miss_d;
  logic             perf_q, perf_d;

  // A note never sits beyond POS_MAX, so the lower bound alone defines the window.
  logic in_window;
  assign in_window = (pos_q >= HIT_LO_V);

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    hit_d   = 1'b0;
    miss_d  = 1'b0;
    perf_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (spawn) begin
          state_d = MOVE;
          pos_d   = '0;
        end
      end
      MOVE: begin
        if (key && in_window) begin
          hit_d   = 1'b1;
          perf_d  = (pos_q == PERFECT_V);
          state_d = IDLE;
          pos_d   = '0;
        end
`ifdef LANE_JUDGE_EARLY_MISS_EN
        else if (key) begin
          miss_d  = 1'b1;
          state_d = IDLE;
          pos_d   = '0;
        end
`endif
        else if (tick) begin
          if (pos_q == POS_MAX_V) begin
            miss_d  = 1'b1;
            state_d = IDLE;
            pos_d   = '0;
          end else begin
            pos_d = pos_q + POS_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        pos_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pos_q   <= '0;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
      perf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      perf_q  <= perf_d;
    end
  end

  assign pos     = pos_q;
  assign active  = (state_q == MOVE);
  assign hit     = hit_q;
  assign miss    = miss_q;
  assign perfect = perf_q;

endmodule

// File: rtl/lane_judge.sv
// Multi-lane note tracker: per-lane FSMs plus saturating global score and combo.
// Optional LANE_JUDGE_EARLY_MISS_EN (see lane_fsm) grades early keys as misses.
module lane_judge
  import lane_judge_pkg::*;
#(
  parameter int LANES   = 4,
  parameter int POS_W   = 4,
  parameter int POS_MAX = 10,
  parameter int HIT_LO  = 8,
  parameter int PERFECT = 9,
  parameter int SCORE_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tick,
  input  logic [LANES-1:0]       spawn,
  input  logic [LANES-1:0]       key,
  output logic [LANES*POS_W-1:0] pos,
  output logic [LANES-1:0]       active,
  output logic [LANES-1:0]       hit,
  output logic [LANES-1:0]       miss,
  output logic [SCORE_W-1:0]     score,
  output logic [COMBO_W-1:0]     combo
);

  localparam int SUM_W = $clog2(INC_PERFECT * LANES + 1);
  localparam int SW1   = SCORE_W + 1;
  localparam int CW1   = COMBO_W + 1;

  logic [LANES-1:0] lane_perf;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    lane_fsm #(
      .POS_W  (POS_W),
      .POS_MAX(POS_MAX),
      .HIT_LO (HIT_LO),
      .PERFECT(PERFECT)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .tick   (tick),
      .spawn  (spawn[gi]),
      .key    (key[gi]),
      .pos    (pos[gi*POS_W +: POS_W]),
      .active (active[gi]),
      .hit    (hit[gi]),
      .miss   (miss[gi]),
      .perfect(lane_perf[gi])
    );
  end

  logic [SUM_W-1:0]   inc_sum;
  logic [SUM_W-1:0]   hit_cnt;
  logic [SW1-1:0]     score_wide;
  logic [CW1-1:0]     combo_wide;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [COMBO_W-1:0] combo_q, combo_d;

  // Score and combo consume the registered hit/miss pulses, so they trail them by one cycle.
  always_comb begin
    inc_sum = '0;
    hit_cnt = '0;
    for (int i = 0; i < LANES; i++) begin
      if (hit[i]) begin
        inc_sum = inc_sum + (lane_perf[i] ? SUM_W'(INC_PERFECT) : SUM_W'(INC_NORMAL));
        hit_cnt = hit_cnt + SUM_W'(1);
      end
    end
    score_wide = {1'b0, score_q} + SW1'(inc_sum);
    combo_wide = {1'b0, combo_q} + CW1'(hit_cnt);
    score_d    = score_wide[SCORE_W] ? '1 : score_wide[SCORE_W-1:0];
    if (|miss) begin
      combo_d = '0;
    end else begin
      combo_d = combo_wide[COMBO_W] ? '1 : combo_wide[COMBO_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      score_q <= '0;
      combo_q <= '0;
    end else begin
      score_q <= score_d;
      combo_q <= combo_d;
    end
  end

  assign score = score_q;
  assign combo = combo_q;

endmodule
